// File: rtl/proj_trig_sched.sv
// Per-frame projector trigger scheduler: after each accepted frame strobe, waits a delay
// and then issues a fixed number of single-cycle start pulses at a fixed period.
module proj_trig_sched #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             frame_start,
    input  logic [CNT_W-1:0] subframe_num,
    input  logic [CNT_W-1:0] subframe_period,
    input  logic [CNT_W-1:0] trig_delay,
    input  logic             clr_err,
    output logic             trig_out,
    output logic [CNT_W-1:0] subframe_idx,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun
);

    typedef enum logic [1:0] {StIdle, StDelay, StFire, StGap} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             trig_q, trig_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovr_q, ovr_d;
    logic             accept;
    logic             last;

    assign accept = (state_q == StIdle) && en && frame_start;
    // A zero-pulse frame parks in StFire for one cycle just to reach completion.
    assign last   = (num_q == '0) || (idx_q == num_q - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    num_d    = subframe_num;
                    period_d = (subframe_period == '0) ? CNT_W'(1) : subframe_period;
                    if (subframe_num == '0) begin
                        state_d = StFire;
                    end else if (trig_delay == '0) begin
                        state_d = StFire;
                        idx_d   = '0;
                    end else begin
                        state_d = StDelay;
                        cnt_d   = trig_delay;
                    end
                end
            end
            StDelay: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StFire;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StFire: begin
                if (last) begin
                    state_d = StIdle;
                end else if (period_q == CNT_W'(1)) begin
                    idx_d = idx_q + CNT_W'(1);
                end else begin
                    state_d = StGap;
                    cnt_d   = period_q - CNT_W'(1);
                end
            end
            StGap: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StFire;
                    idx_d   = idx_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        if (!en) begin
            state_d = StIdle;
            idx_d   = idx_q;
        end
    end

    // Registered outputs are derived from the state being entered.
    always_comb begin
        trig_d = (state_d == StFire) && (num_d != '0);
        busy_d = (state_d != StIdle);
        done_d = (state_q == StFire) && last && en;
        ovr_d  = (frame_start && busy_q) || (ovr_q && !clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_q    <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            trig_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            num_q    <= num_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            trig_q   <= trig_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
        end
    end

    assign trig_out     = trig_q;
    assign subframe_idx = idx_q;
    assign busy         = busy_q;
    assign frame_done   = done_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_proj_trig_sched.sv
// Directed bench for proj_trig_sched; frame schedules are checked against the
// closed-form cycle timing of pulses, busy and frame_done.
module tb_proj_trig_sched;

    logic        clk, rst, en, frame_start, clr_err;
    logic [31:0] subframe_num, subframe_period, trig_delay;
    logic        trig_out, busy, frame_done, overrun;
    logic [31:0] subframe_idx;
    int          errors = 0;
    int          checks = 0;

    proj_trig_sched #(.CNT_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .frame_start     (frame_start),
        .subframe_num    (subframe_num),
        .subframe_period (subframe_period),
        .trig_delay      (trig_delay),
        .clr_err         (clr_err),
        .trig_out        (trig_out),
        .subframe_idx    (subframe_idx),
        .busy            (busy),
        .frame_done      (frame_done),
        .overrun         (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a frame in the current cycle (cycle 0), switches config to the mid values
    // from cycle 1, and checks cycles 1..ncyc against the expected schedule.
    task automatic run_frame(input string tag, input int d, input int p, input int n,
                             input int md, input int mp, input int mn, input int ncyc);
        int pc, dc, k;
        bit et;
        pc = (p == 0) ? 1 : p;
        dc = (n == 0) ? 2 : 2 + d + (n - 1) * pc;
        trig_delay = d; subframe_period = p; subframe_num = n;
        en = 1'b1; frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        trig_delay = md; subframe_period = mp; subframe_num = mn;
        for (int c = 1; c <= ncyc; c++) begin
            k  = (c - 1 - d) / pc;
            et = (n > 0) && (c >= 1 + d) && (((c - 1 - d) % pc) == 0) && (k < n);
            chk($sformatf("%s_trig_c%0d", tag, c), {31'd0, trig_out}, {31'd0, et});
            chk($sformatf("%s_busy_c%0d", tag, c), {31'd0, busy}, {31'd0, c < dc});
            chk($sformatf("%s_done_c%0d", tag, c), {31'd0, frame_done}, {31'd0, c == dc});
            if (et) chk($sformatf("%s_idx_c%0d", tag, c), subframe_idx, k);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; frame_start = 1'b0; clr_err = 1'b0;
        subframe_num = '0; subframe_period = '0; trig_delay = '0;
        tick();
        tick();
        chk("rst_trig", {31'd0, trig_out}, 32'd0);
        chk("rst_idx", subframe_idx, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        rst = 1'b0; en = 1'b1;
        tick();

        // Basic schedule, period clamp, zero-pulse frame.
        run_frame("t1", 3, 10, 4, 3, 10, 4, 37);
        run_frame("t2", 0, 0, 3, 0, 0, 3, 6);
        run_frame("t3", 5, 7, 0, 5, 7, 0, 5);

        // Overrun, back-to-back accept at frame_done, clr_err vs set priority.
        trig_delay = 0; subframe_period = 5; subframe_num = 2; frame_start = 1'b1;
        tick();                                      // cycle 1
        frame_start = 1'b0;
        chk("t4_trig_c1", {31'd0, trig_out}, 32'd1);
        chk("t4_busy_c1", {31'd0, busy}, 32'd1);
        tick(); tick();                              // cycle 3
        frame_start = 1'b1;
        tick();                                      // cycle 4
        frame_start = 1'b0;
        chk("t4_ovr_c4", {31'd0, overrun}, 32'd1);
        chk("t4_busy_c4", {31'd0, busy}, 32'd1);
        tick(); tick();                              // cycle 6
        chk("t4_trig_c6", {31'd0, trig_out}, 32'd1);
        chk("t4_idx_c6", subframe_idx, 32'd1);
        tick();                                      // cycle 7
        chk("t4_done_c7", {31'd0, frame_done}, 32'd1);
        chk("t4_busy_c7", {31'd0, busy}, 32'd0);
        frame_start = 1'b1;
        tick();                                      // cycle 8
        frame_start = 1'b0;
        chk("t4_busy_c8", {31'd0, busy}, 32'd1);
        chk("t4_trig_c8", {31'd0, trig_out}, 32'd1);
        chk("t4_idx_c8", subframe_idx, 32'd0);
        chk("t4_ovr_c8", {31'd0, overrun}, 32'd1);
        tick();                                      // cycle 9
        frame_start = 1'b1; clr_err = 1'b1;
        tick();                                      // cycle 10
        frame_start = 1'b0; clr_err = 1'b0;
        chk("t4_ovr_setwins", {31'd0, overrun}, 32'd1);
        repeat (5) tick();                           // cycle 15, second frame done at 14
        chk("t4_busy_c15", {31'd0, busy}, 32'd0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t4_ovr_clr", {31'd0, overrun}, 32'd0);
        tick();

        // Abort via en.
        trig_delay = 2; subframe_period = 8; subframe_num = 10; frame_start = 1'b1;
        tick();                                      // cycle 1
        frame_start = 1'b0;
        repeat (18) tick();                          // cycle 19
        chk("t5_trig_c19", {31'd0, trig_out}, 32'd1);
        chk("t5_idx_c19", subframe_idx, 32'd2);
        tick();                                      // cycle 20
        en = 1'b0;
        tick();                                      // cycle 21
        chk("t5_trig_c21", {31'd0, trig_out}, 32'd0);
        chk("t5_busy_c21", {31'd0, busy}, 32'd0);
        chk("t5_done_c21", {31'd0, frame_done}, 32'd0);
        chk("t5_idx_c21", subframe_idx, 32'd2);
        for (int c = 22; c < 40; c++) begin
            tick();
            chk($sformatf("t5_quiet_c%0d", c), {30'd0, trig_out, frame_done}, 32'd0);
        end
        en = 1'b1;
        tick();

        // Abort via rst, with overrun set beforehand.
        frame_start = 1'b1;
        tick();                                      // cycle 1
        frame_start = 1'b0;
        repeat (4) tick();                           // cycle 5
        frame_start = 1'b1;
        tick();                                      // cycle 6
        frame_start = 1'b0;
        chk("t5r_ovr_c6", {31'd0, overrun}, 32'd1);
        repeat (14) tick();                          // cycle 20
        rst = 1'b1;
        tick();                                      // cycle 21
        rst = 1'b0;
        chk("t5r_trig", {31'd0, trig_out}, 32'd0);
        chk("t5r_idx", subframe_idx, 32'd0);
        chk("t5r_busy", {31'd0, busy}, 32'd0);
        chk("t5r_done", {31'd0, frame_done}, 32'd0);
        chk("t5r_ovr", {31'd0, overrun}, 32'd0);
        for (int c = 22; c < 32; c++) begin
            tick();
            chk($sformatf("t5r_quiet_c%0d", c), {29'd0, trig_out, busy, frame_done}, 32'd0);
        end

        // Mid-frame config changes only affect the next frame.
        run_frame("t6a", 1, 3, 3, 4, 2, 7, 12);
        run_frame("t6b", 4, 2, 7, 4, 2, 7, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/proj_trig_sched.md
# proj_trig_sched

Per-frame projector trigger scheduler. On each camera frame-start strobe it waits a programmable delay, then issues a programmable number of single-cycle start pulses at a fixed period. Its trig_out drives trig_in of the projector trigger pulse-train generator, which shapes each start into the projector's pulse train. Reports busy, frame completion and overrun status to the host register bank.

## Interface
- CNT_W, 32: width of all count/config ports; matches the downstream generator's 32-bit configuration.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  scheduler enable; low aborts any frame and blocks new ones
- frame_start  in  1  single-cycle frame strobe from the camera sequencer
- subframe_num  in  CNT_W  trig_out pulses per frame; latched at accept
- subframe_period  in  CNT_W  cycles between successive trig_out pulses; latched at accept
- trig_delay  in  CNT_W  cycles from accept to first pulse; latched at accept
- clr_err  in  1  clears overrun
- trig_out  out  1  single-cycle start pulse to the downstream generator
- subframe_idx  out  CNT_W  index of the most recent pulse, 0-based
- busy  out  1  frame in progress
- frame_done  out  1  single-cycle pulse when a frame's last pulse has been issued
- overrun  out  1  sticky: frame_start arrived while busy

## Operation
- States: IDLE, DELAY, FIRE, GAP. IDLE is the reset state.
- Accept: in IDLE with en=1 and frame_start=1, latch the three config inputs. Clamp the latched period: 0 becomes 1. Set busy.
  - If the latched num = 0: go straight to the completion step; no trig_out, frame_done asserted next cycle.
  - Otherwise go to DELAY.
- DELAY: counts trig_delay cycles, then issues the first pulse (FIRE).
- FIRE: trig_out=1 for exactly one cycle and subframe_idx updates to the pulse number.
  - If this was pulse num-1: frame_done=1 next cycle, busy=0 in that same cycle, return to IDLE.
  - Otherwise go to GAP.
- GAP: waits so that consecutive trig_out rising cycles are exactly period cycles apart.
  - period=1 gives trig_out high on consecutive cycles, one pulse per cycle.
- Overrun: frame_start while busy=1 is ignored and sets overrun. overrun holds until clr_err=1 or rst.
  - clr_err and a new overrun in the same cycle: overrun stays 1 (set wins).
- frame_start in the frame_done cycle (busy=0) is accepted normally; no overrun.
- en=0 while busy: abort. Next cycle: IDLE, busy=0, trig_out=0. No frame_done; subframe_idx holds.
- Config inputs changing mid-frame have no effect until the next accept.
- Counters are CNT_W wide and compared unsigned, with no wrap inside a frame: max delay 2^32-1, max num 2^32-1.
- Reset values: trig_out=0, subframe_idx=0, busy=0, frame_done=0, overrun=0, state IDLE.
- rst mid-frame returns all outputs to their reset values on the next edge.

## Timing
- Cycle 0 is the cycle in which frame_start is sampled high.
- busy is high from cycle 1.
- Pulse k (0-based) has trig_out high in cycle 1 + D + k·P, where D = latched delay and P = clamped period.
- subframe_idx = k from the same cycle as pulse k, held until the next pulse.
- frame_done is high in cycle 2 + D + (N-1)·P. busy is low from that cycle.
- For N=0: busy high in cycle 1 only, frame_done high in cycle 2.
- All outputs are registered, with no combinational path from inputs to outputs.
- Downstream requirement: the generator restarts on every trig_out pulse. P must be at least the generator's train length; this block does not enforce it.

## Test plan
- D=3, P=10, N=4, frame_start in cycle 0 -> trig_out high in cycles 4, 14, 24, 34; subframe_idx 0..3; frame_done in cycle 35; busy high in cycles 1–34.
- D=0, P=0, N=3 -> trig_out high in cycles 1, 2, 3; frame_done in cycle 4.
- N=0, D=5 -> no trig_out; busy high in cycle 1 only; frame_done in cycle 2.
- Frame with D=0, P=5, N=2 running; second frame_start in cycle 3 -> ignored, overrun=1 from cycle 4. frame_start in the frame_done cycle (cycle 7) -> new frame accepted, overrun unchanged. clr_err pulse -> overrun=0 next cycle.
- Run D=2, P=8, N=10; drop en in cycle 20 -> trig_out stays 0 from cycle 21, busy=0 in cycle 21, no frame_done. The same abort via rst -> all outputs at reset values, overrun=0.
- Change num, period and delay mid-frame -> the current frame's pulse schedule is unchanged; the next frame uses the new values.
